fetch_req_arbiter: RTL
======================

FETCH_REQ_ARBITER -- requirements
Module: fetch_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: maximum WAIT-state cycles before the outstanding request is abandoned.
REQ-002 Parameter STARVE_LIMIT, default 3: maximum consecutive branch grants while a prefetch request is pending.
REQ-003 The clock SHALL be clk; reset SHALL be reset, synchronous, active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 flush_in  in  1  mispredict flush; cancels or discards the current request.
REQ-007 pf_req_valid  in  1; pf_req_addr  in  32; pf_req_ready  out  1: sequential-prefetch requester handshake.
REQ-008 br_req_valid  in  1; br_req_addr  in  32; br_req_ready  out  1: branch-target requester handshake.
REQ-009 cache_req_valid  out  1; cache_req_addr  out  32; cache_req_ready  in  1: I-cache request port.
REQ-010 cache_rvalid_in  in  1; cache_rdata_in  in  128: I-cache response, 4 instructions.
REQ-011 resp_valid  out  1; resp_data  out  128; resp_addr  out  32; resp_src  out  1 (0=prefetch, 1=branch): delivered block.
REQ-012 busy_out  out  1 (state != IDLE); timeout_err  out  1 (one-cycle pulse).

Function
REQ-013 The block SHALL implement FSM states IDLE, ISSUE, WAIT and DRAIN, with at most one cache request outstanding.
REQ-014 In IDLE with flush_in low, the block SHALL assert exactly one of br_req_ready or pf_req_ready combinationally: branch if br_req_valid, else prefetch.
REQ-015 Starvation guard: if the starve counter equals STARVE_LIMIT and pf_req_valid is high, the grant SHALL go to prefetch even if br_req_valid is high.
REQ-016 Starve counter: increment on a branch grant while pf_req_valid is high; clear on any prefetch grant; saturate at STARVE_LIMIT.
REQ-017 A grant (valid&&ready) in cycle N SHALL latch the address with [3:0] forced to 0, latch the source, and enter ISSUE in N+1.
REQ-018 In ISSUE, cache_req_valid SHALL be 1 and cache_req_addr SHALL equal the latched address, held stable until cache_req_ready is sampled high; the FSM then enters WAIT.
REQ-019 In WAIT, a 5-bit counter SHALL count from 0; cache_rvalid_in high SHALL register cache_rdata_in, the latched address and the source onto the resp_* outputs, pulse resp_valid in the next cycle, and return to IDLE.
REQ-020 When the WAIT counter reaches TIMEOUT_CYC-1 without cache_rvalid_in, the block SHALL pulse timeout_err, produce no resp_valid, and enter DRAIN.
REQ-021 flush_in in IDLE SHALL suppress both ready outputs that cycle; flush has priority over simultaneous requests.
REQ-022 flush_in in ISSUE SHALL deassert cache_req_valid the next cycle and enter IDLE if cache_req_ready is low that cycle; if it is high, the FSM SHALL enter DRAIN.
REQ-023 flush_in in WAIT SHALL enter DRAIN; a cache_rvalid_in in the same cycle SHALL be discarded.
REQ-024 In DRAIN, the block SHALL wait for cache_rvalid_in, discard the data (no resp_valid), and return to IDLE the cycle after; further flush_in pulses SHALL have no effect.
REQ-025 Outside WAIT, cache_rvalid_in SHALL be ignored.
REQ-026 Both ready outputs SHALL be 0 in every state other than IDLE.

Reset
REQ-027 reset SHALL force IDLE, clear the starve and WAIT counters, and drive cache_req_valid, resp_valid, timeout_err, busy_out and resp_src to 0, with resp_data/resp_addr=0.
REQ-028 reset asserted mid-request SHALL abandon the request without resp_valid; any later cache_rvalid_in SHALL be ignored in IDLE.

Verification
REQ-029 pf_req_valid=1 with addr 0x1004, cache_req_ready=1, rvalid 3 cycles later with data D -> cache_req_addr=0x1000, resp_valid one cycle after rvalid, resp_data=D, resp_addr=0x1000, resp_src=0.
REQ-030 pf and br both valid in IDLE -> br_req_ready=1, pf_req_ready=0; after 3 consecutive branch grants with pf held, the 4th grant goes to prefetch.
REQ-031 flush_in during WAIT, then rvalid 2 cycles later -> no resp_valid; FSM returns to IDLE and the next request is granted normally.
REQ-032 cache_req_ready held low 5 cycles -> cache_req_valid and cache_req_addr stable throughout; WAIT is entered only after ready is sampled high.
REQ-033 No rvalid for 15 WAIT cycles -> timeout_err pulses once, DRAIN is held until rvalid arrives, that response is dropped, then IDLE.
REQ-034 reset asserted in ISSUE -> next cycle cache_req_valid=0, busy_out=0, and all outputs are at reset values.

Source files
------------

// File: rtl/fetch_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_req_arbiter: prefetch/branch fetch arbiter, one I-cache req in flight |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_req_arbiter #(
  parameter int TIMEOUT_CYC  = 15,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_in,
  input  logic         pf_req_valid,
  input  logic [31:0]  pf_req_addr,
  output logic         pf_req_ready,
  input  logic         br_req_valid,
  input  logic [31:0]  br_req_addr,
  output logic         br_req_ready,
  output logic         cache_req_valid,
  output logic [31:0]  cache_req_addr,
  input  logic         cache_req_ready,
  input  logic         cache_rvalid_in,
  input  logic [127:0] cache_rdata_in,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic [31:0]  resp_addr,
  output logic         resp_src,
  output logic         busy_out,
  output logic         timeout_err
);

  localparam int c_STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  localparam logic [4:0] c_WAIT_LAST = 5'(TIMEOUT_CYC - 1);
  localparam logic [31:0] c_LINE_MASK = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_STARVE_W-1:0] r_starve;
  logic [4:0]            r_wait_cnt;
  logic [31:0]           r_addr;
  logic                  r_src;
  logic                  r_cache_req_valid;
  logic                  r_resp_valid;
  logic [127:0]          r_resp_data;
  logic [31:0]           r_resp_addr;
  logic                  r_resp_src;
  logic                  r_timeout_err;

  logic w_idle;
  logic w_starve_hit;
  logic w_br_ready;
  logic w_pf_ready;
  logic w_br_grant;
  logic w_pf_grant;

  // Prefetch is the fallback grant, so exactly one ready is high in an unflushed IDLE.
  assign w_idle       = (r_state == S_IDLE);
  assign w_starve_hit = (r_starve == c_STARVE_MAX) && pf_req_valid;
  assign w_br_ready   = w_idle && !flush_in && br_req_valid && !w_starve_hit;
  assign w_pf_ready   = w_idle && !flush_in && !w_br_ready;
  assign w_br_grant   = w_br_ready && br_req_valid;
  assign w_pf_grant   = w_pf_ready && pf_req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_starve          <= '0;
      r_wait_cnt        <= 5'd0;
      r_addr            <= 32'd0;
      r_src             <= 1'b0;
      r_cache_req_valid <= 1'b0;
      r_resp_valid      <= 1'b0;
      r_resp_data       <= 128'd0;
      r_resp_addr       <= 32'd0;
      r_resp_src        <= 1'b0;
      r_timeout_err     <= 1'b0;
    end else begin
      r_resp_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_br_grant || w_pf_grant) begin
            r_addr            <= (w_br_grant ? br_req_addr : pf_req_addr) & c_LINE_MASK;
            r_src             <= w_br_grant;
            r_cache_req_valid <= 1'b1;
            r_state           <= S_ISSUE;
            if (w_pf_grant)
              r_starve <= '0;
            else if (pf_req_valid && (r_starve != c_STARVE_MAX))
              r_starve <= r_starve + 1'b1;
          end
        end
        S_ISSUE: begin
          // An accepted request must still have its response drained after a flush.
          if (flush_in) begin
            r_cache_req_valid <= 1'b0;
            r_state           <= cache_req_ready ? S_DRAIN : S_IDLE;
          end else if (cache_req_ready) begin
            r_cache_req_valid <= 1'b0;
            r_wait_cnt        <= 5'd0;
            r_state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_in) begin
            r_state <= S_DRAIN;
          end else if (cache_rvalid_in) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= cache_rdata_in;
            r_resp_addr  <= r_addr;
            r_resp_src   <= r_src;
            r_state      <= S_IDLE;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_DRAIN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 5'd1;
          end
        end
        S_DRAIN: begin
          if (cache_rvalid_in)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign br_req_ready    = w_br_ready;
  assign pf_req_ready    = w_pf_ready;
  assign cache_req_valid = r_cache_req_valid;
  assign cache_req_addr  = r_addr;
  assign resp_valid      = r_resp_valid;
  assign resp_data       = r_resp_data;
  assign resp_addr       = r_resp_addr;
  assign resp_src        = r_resp_src;
  assign busy_out        = (r_state != S_IDLE);
  assign timeout_err     = r_timeout_err;

endmodule
`default_nettype wire
